// File: rtl/sha256_axi_burst_regs.sv
// sha256_axi_burst_regs: AXI4-full burst slave in front of the SHA-256 core.
// Holds the message block, CTRL/STATUS and a read-only digest window.
// The write and read engines are independent.
module sha256_axi_burst_regs #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int NUM_RW             = 16,
    parameter int NUM_RO             = 8
) (
    input  logic                                   s00_axi_aclk,
    input  logic                                   s00_axi_areset,
    input  logic [C_S_AXI_ID_WIDTH-1:0]            s00_axi_awid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_awaddr,
    input  logic [7:0]                             s00_axi_awlen,
    input  logic [2:0]                             s00_axi_awsize,
    input  logic [1:0]                             s00_axi_awburst,
    input  logic                                   s00_axi_awlock,
    input  logic [3:0]                             s00_axi_awcache,
    input  logic [2:0]                             s00_axi_awprot,
    input  logic [3:0]                             s00_axi_awqos,
    input  logic [3:0]                             s00_axi_awregion,
    input  logic                                   s00_axi_awvalid,
    output logic                                   s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s00_axi_wstrb,
    input  logic                                   s00_axi_wlast,
    input  logic                                   s00_axi_wvalid,
    output logic                                   s00_axi_wready,
    output logic [C_S_AXI_ID_WIDTH-1:0]            s00_axi_bid,
    output logic [1:0]                             s00_axi_bresp,
    output logic                                   s00_axi_bvalid,
    input  logic                                   s00_axi_bready,
    input  logic [C_S_AXI_ID_WIDTH-1:0]            s00_axi_arid,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s00_axi_araddr,
    input  logic [7:0]                             s00_axi_arlen,
    input  logic [2:0]                             s00_axi_arsize,
    input  logic [1:0]                             s00_axi_arburst,
    input  logic                                   s00_axi_arlock,
    input  logic [3:0]                             s00_axi_arcache,
    input  logic [2:0]                             s00_axi_arprot,
    input  logic [3:0]                             s00_axi_arqos,
    input  logic [3:0]                             s00_axi_arregion,
    input  logic                                   s00_axi_arvalid,
    output logic                                   s00_axi_arready,
    output logic [C_S_AXI_ID_WIDTH-1:0]            s00_axi_rid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          s00_axi_rdata,
    output logic [1:0]                             s00_axi_rresp,
    output logic                                   s00_axi_rlast,
    output logic                                   s00_axi_rvalid,
    input  logic                                   s00_axi_rready,
    output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0]   blk_data,
    output logic                                   core_init,
    output logic                                   core_start,
    input  logic                                   core_busy,
    input  logic                                   core_done,
    input  logic [NUM_RO*C_S_AXI_DATA_WIDTH-1:0]   digest
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int B  = DW / 8;
    localparam int LB = $clog2(B);
    localparam logic [AW-1:0] IDX_CTRL  = AW'(NUM_RW);
    localparam logic [AW-1:0] IDX_STAT  = AW'(NUM_RW + 1);
    localparam logic [AW-1:0] IDX_DLAST = AW'(NUM_RW + 1 + NUM_RO);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    // Address of the beat after 'a'; WRAP only wraps for legal lengths.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                                input logic [7:0] len,
                                                input logic [1:0] burst);
        logic [AW-1:0] inc;
        logic [AW-1:0] mask;
        inc  = a + AW'(B);
        mask = '0;
        case (burst)
            2'b00:   next_addr = a;
            2'b10: begin
                case (len)
                    8'd1:    mask = AW'(2 * B - 1);
                    8'd3:    mask = AW'(4 * B - 1);
                    8'd7:    mask = AW'(8 * B - 1);
                    8'd15:   mask = AW'(16 * B - 1);
                    default: mask = '0;
                endcase
                if (mask == '0) next_addr = inc;
                else            next_addr = (a & ~mask) | (inc & mask);
            end
            default: next_addr = inc;
        endcase
    endfunction

    w_state_t w_state_r, w_next_s;
    r_state_t r_state_r, r_next_s;
    logic awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
    logic aw_rdy_s, w_rdy_s, b_vld_s, ar_rdy_s, r_vld_s;
    logic [C_S_AXI_ID_WIDTH-1:0] bid_r, rid_r;
    logic [AW-1:0] w_addr_r, r_addr_r, wr_idx_s, rd_addr_s, rd_idx_s;
    logic [7:0] w_len_r, w_cnt_r, r_len_r, r_cnt_r;
    logic [1:0] w_burst_r, r_burst_r, bresp_r, rresp_r;
    logic [DW-1:0] rdata_r, rd_data_s;
    logic rlast_r, rd_err_s;
    logic [NUM_RW*DW-1:0] blk_r;
    logic done_r, overrun_r, core_init_r, core_start_r;
    logic wr_msg_s, wr_ctrl_s, wr_err_s, ctrl_act_s;
    logic init_req_s, start_req_s, ovr_req_s;
    logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, r_final_s;
    logic unused_s;

    assign unused_s = &{1'b0, s00_axi_awsize, s00_axi_awlock, s00_axi_awcache, s00_axi_awprot,
                        s00_axi_awqos, s00_axi_awregion, s00_axi_wlast, s00_axi_arsize,
                        s00_axi_arlock, s00_axi_arcache, s00_axi_arprot, s00_axi_arqos,
                        s00_axi_arregion};

    assign aw_hs_s   = s00_axi_awvalid & awready_r;
    assign w_hs_s    = s00_axi_wvalid & wready_r;
    assign b_hs_s    = s00_axi_bready & bvalid_r;
    assign ar_hs_s   = s00_axi_arvalid & arready_r;
    assign r_hs_s    = s00_axi_rready & rvalid_r;
    assign r_final_s = r_hs_s & (r_cnt_r == r_len_r);

    // Write FSM state register with registered handshake outputs.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
        end else begin
            w_state_r <= w_next_s;
            awready_r <= aw_rdy_s;
            wready_r  <= w_rdy_s;
            bvalid_r  <= b_vld_s;
        end
    end

    // Write FSM next state; the beat counter, not wlast, ends the burst.
    always_comb begin
        w_next_s = w_state_r;
        case (w_state_r)
            W_IDLE:  w_next_s = aw_hs_s ? W_DATA : W_IDLE;
            W_DATA:  w_next_s = (w_hs_s && (w_cnt_r == w_len_r)) ? W_RESP : W_DATA;
            W_RESP:  w_next_s = b_hs_s ? W_IDLE : W_RESP;
            default: w_next_s = W_IDLE;
        endcase
    end

    // Write FSM outputs for the upcoming state.
    always_comb begin
        aw_rdy_s = (w_next_s == W_IDLE);
        w_rdy_s  = (w_next_s == W_DATA);
        b_vld_s  = (w_next_s == W_RESP);
    end

    // Write burst context: id, address walk, beat count, sticky error.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            bid_r <= '0; w_addr_r <= '0; w_len_r <= 8'd0;
            w_burst_r <= 2'b00; w_cnt_r <= 8'd0; bresp_r <= 2'b00;
        end else if (aw_hs_s) begin
            bid_r     <= s00_axi_awid;
            w_addr_r  <= s00_axi_awaddr;
            w_len_r   <= s00_axi_awlen;
            w_burst_r <= s00_axi_awburst;
            w_cnt_r   <= 8'd0;
            bresp_r   <= 2'b00;
        end else if (w_hs_s) begin
            w_addr_r <= next_addr(w_addr_r, w_len_r, w_burst_r);
            w_cnt_r  <= w_cnt_r + 8'd1;
            if (wr_err_s) bresp_r <= 2'b10;
        end
    end

    // Classify the current write beat by word index.
    always_comb begin
        wr_idx_s  = w_addr_r >> LB;
        wr_msg_s  = 1'b0;
        wr_ctrl_s = 1'b0;
        wr_err_s  = 1'b0;
        if (w_hs_s) begin
            if (wr_idx_s < IDX_CTRL)       wr_msg_s  = 1'b1;
            else if (wr_idx_s == IDX_CTRL) wr_ctrl_s = 1'b1;
            else                           wr_err_s  = 1'b1;
        end else begin
            wr_msg_s = 1'b0;
        end
    end

    // Init wins over start; start while busy only flags overrun.
    assign ctrl_act_s  = wr_ctrl_s & s00_axi_wstrb[0];
    assign init_req_s  = ctrl_act_s & s00_axi_wdata[1];
    assign start_req_s = ctrl_act_s & s00_axi_wdata[0] & ~s00_axi_wdata[1] & ~core_busy;
    assign ovr_req_s   = ctrl_act_s & s00_axi_wdata[0] & ~s00_axi_wdata[1] & core_busy;

    // Byte-enabled update of the message words.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            blk_r <= '0;
        end else if (wr_msg_s) begin
            for (int i = 0; i < NUM_RW; i++) begin
                for (int b = 0; b < B; b++) begin
                    if ((wr_idx_s == AW'(i)) && s00_axi_wstrb[b])
                        blk_r[i*DW + b*8 +: 8] <= s00_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Core pulses and sticky status; core_done beats a same-cycle clear.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            core_init_r <= 1'b0; core_start_r <= 1'b0;
            done_r <= 1'b0; overrun_r <= 1'b0;
        end else begin
            core_init_r  <= init_req_s;
            core_start_r <= start_req_s;
            if (core_done)                      done_r <= 1'b1;
            else if (init_req_s || start_req_s) done_r <= 1'b0;
            if (init_req_s)     overrun_r <= 1'b0;
            else if (ovr_req_s) overrun_r <= 1'b1;
        end
    end

    // Read FSM state register with registered handshake outputs.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
        end else begin
            r_state_r <= r_next_s;
            arready_r <= ar_rdy_s;
            rvalid_r  <= r_vld_s;
        end
    end

    // Read FSM next state.
    always_comb begin
        r_next_s = r_state_r;
        case (r_state_r)
            R_IDLE:  r_next_s = ar_hs_s ? R_DATA : R_IDLE;
            R_DATA:  r_next_s = r_final_s ? R_IDLE : R_DATA;
            default: r_next_s = R_IDLE;
        endcase
    end

    // Read FSM outputs for the upcoming state.
    always_comb begin
        ar_rdy_s = (r_next_s == R_IDLE);
        r_vld_s  = (r_next_s == R_DATA);
    end

    // Look up the word for the beat about to be loaded into rdata.
    always_comb begin
        rd_addr_s = (r_state_r == R_IDLE) ? s00_axi_araddr
                                          : next_addr(r_addr_r, r_len_r, r_burst_r);
        rd_idx_s  = rd_addr_s >> LB;
        rd_data_s = '0;
        rd_err_s  = 1'b0;
        if (rd_idx_s < IDX_CTRL)        rd_data_s = blk_r[int'(rd_idx_s)*DW +: DW];
        else if (rd_idx_s == IDX_CTRL)  rd_data_s = '0;
        else if (rd_idx_s == IDX_STAT)  rd_data_s = DW'({overrun_r, done_r, core_busy});
        else if (rd_idx_s <= IDX_DLAST) rd_data_s = digest[(int'(rd_idx_s) - NUM_RW - 2)*DW +: DW];
        else                            rd_err_s  = 1'b1;
    end

    // Read burst context and registered beat data.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            rid_r <= '0; r_addr_r <= '0; r_len_r <= 8'd0; r_burst_r <= 2'b00;
            r_cnt_r <= 8'd0; rdata_r <= '0; rresp_r <= 2'b00; rlast_r <= 1'b0;
        end else if (ar_hs_s) begin
            rid_r     <= s00_axi_arid;
            r_addr_r  <= s00_axi_araddr;
            r_len_r   <= s00_axi_arlen;
            r_burst_r <= s00_axi_arburst;
            r_cnt_r   <= 8'd0;
            rdata_r   <= rd_data_s;
            rresp_r   <= rd_err_s ? 2'b10 : 2'b00;
            rlast_r   <= (s00_axi_arlen == 8'd0);
        end else if (r_hs_s && !r_final_s) begin
            r_addr_r <= rd_addr_s;
            r_cnt_r  <= r_cnt_r + 8'd1;
            rdata_r  <= rd_data_s;
            rresp_r  <= rd_err_s ? 2'b10 : 2'b00;
            rlast_r  <= ((r_cnt_r + 8'd1) == r_len_r);
        end
    end

    assign s00_axi_awready = awready_r;
    assign s00_axi_wready  = wready_r;
    assign s00_axi_bvalid  = bvalid_r;
    assign s00_axi_bid     = bid_r;
    assign s00_axi_bresp   = bresp_r;
    assign s00_axi_arready = arready_r;
    assign s00_axi_rvalid  = rvalid_r;
    assign s00_axi_rid     = rid_r;
    assign s00_axi_rdata   = rdata_r;
    assign s00_axi_rresp   = rresp_r;
    assign s00_axi_rlast   = rlast_r;
    assign blk_data        = blk_r;
    assign core_init       = core_init_r;
    assign core_start      = core_start_r;
endmodule
